buzzer_tone_seq: RTL and testbench
==================================

Name: buzzer_tone_seq

Overview:
- Tone-sequencer core directly downstream of the myBuzzer AXI4-Lite register file. It consumes the decoded slave-register fields and drives the physical buzzer pin.
- Generates a square-wave tone of programmable half-period for a programmed on-time. Inserts a programmed silent gap and repeats N beeps.
- Reports busy, done and beep-count back to the register file for readback.

Parameters:
- CLK_FREQ_HZ, 100_000_000: frequency of s00_axi_aclk.
- TICK_HZ, 1000: duration time base. One tick = CLK_FREQ_HZ/TICK_HZ cycles; must divide evenly and give ≥2.
- HP_WIDTH, 32: width of the half-period field.

Ports:
- s00_axi_aclk  in  1  clock.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- ctrl_enable  in  1  level; block enable (reg0[0]).
- ctrl_start  in  1  single-cycle pulse; begin sequence.
- ctrl_abort  in  1  single-cycle pulse; stop immediately.
- cfg_half_period  in  HP_WIDTH  clocks per tone half-cycle; 0 = rest (silent).
- cfg_duration  in  16  on-time per beep, in ticks.
- cfg_gap  in  16  silence after each non-final beep, in ticks.
- cfg_repeat  in  8  number of beeps; 0 treated as 1.
- buzzer_out  out  1  tone output.
- busy  out  1  sequence in progress.
- done  out  1  sticky; set on normal completion, cleared by the next accepted start.
- beep_count  out  8  beeps completed in current/last sequence.

Behaviour:
- Reset (async assert, sync release): state IDLE, buzzer_out=0, busy=0, done=0, beep_count=0, all counters 0. All outputs are registered.
- FSM states are IDLE, PLAY and GAP.
- IDLE→PLAY: on start && enable && !abort, sampled at edge N.
  - At edge N, cfg_* fields are latched; later cfg changes have no effect until the next start.
  - Also at edge N: beep_count←0, done←0, tick prescaler←0, tone counter←0, duration counter←0.
  - From cycle N+1: busy=1, buzzer_out=1 (0 if latched half_period==0).
- Start while busy is ignored. Start with enable=0 is ignored.
- PLAY behaviour:
  - Tone counter counts 0..half_period-1.
  - At terminal count, buzzer_out toggles and the counter wraps to 0, giving a period of 2*half_period cycles.
  - half_period==1 toggles every cycle.
  - Prescaler pulses tick every CLK_FREQ_HZ/TICK_HZ cycles. The duration counter increments on tick.
- PLAY exit, taken when the duration counter reaches the latched duration:
  - beep_count increments.
  - If beep_count+1 == effective repeat → IDLE with busy←0, done←1, buzzer_out←0.
  - Else if gap==0 → re-enter PLAY: buzzer_out←1, tone/prescaler/duration counters←0.
  - Else → GAP with buzzer_out←0.
- duration==0: PLAY lasts exactly one cycle (buzzer_out high for that cycle), then exits as above.
- GAP:
  - buzzer_out=0.
  - The prescaler continues from 0, which is cleared on GAP entry.
  - After gap ticks → PLAY, with counters cleared and buzzer_out←1.
- Abort, or enable deasserted, in PLAY/GAP:
  - At the next edge: IDLE, buzzer_out←0, busy←0, done unchanged (stays 0).
  - beep_count holds the completed count.
- Abort and start in the same cycle: abort wins, start is dropped.
- Counter widths:
  - Tone counter is HP_WIDTH bits.
  - Prescaler is clog2(CLK_FREQ_HZ/TICK_HZ) bits.
  - Duration/gap counter is 16 bits; no overflow is possible since it compares ≤ the latched value.
  - Effective repeat is 8 bits, so a maximum of 255 beeps; beep_count never wraps.
- Reset asserted mid-sequence: immediate return to reset values; buzzer_out drops asynchronously.

Decomposition:
- Package buzzer_pkg holds:
  - enum state_t {IDLE, PLAY, GAP}
  - function tick_div(CLK_FREQ_HZ, TICK_HZ)
  - localparams DUR_W=16 and REP_W=8
- Sub-module buzzer_tick_prescaler:
  - Inputs: clk, rst_n, clear, run.
  - Output: tick, a one-cycle pulse every DIV cycles while run is high.
  - Instantiated once.
- The tone divider and FSM stay in the top.

Test Plan (CLK_FREQ_HZ=1000, TICK_HZ=100 → tick every 10 cycles):
1. Reset:
   - Stimulus: hold aresetn=0, toggle inputs.
   - Required: buzzer_out/busy/done=0, beep_count=0. Assert reset mid-PLAY → buzzer_out=0 in the same cycle.
2. Normal sequence:
   - Stimulus: half=2, dur=3, gap=2, rep=2; start at cycle N.
   - Required: buzzer_out high at N+1, toggles every 2 cycles during each 30-cycle PLAY, low for the 20-cycle GAP.
   - Required: busy high 80 cycles, then done=1, beep_count=2, buzzer_out=0.
3. Rest and edge values:
   - Stimulus: half=0, dur=3, rep=1.
   - Required: buzzer_out stays 0, busy for 30 cycles, done=1.
   - Stimulus: rep=0, dur=0.
   - Required: one 1-cycle beep, beep_count=1.
4. Abort:
   - Stimulus: abort 12 cycles into PLAY of a rep=3 sequence.
   - Required: next cycle IDLE, buzzer_out=0, busy=0, done=0, beep_count=1 if the first beep had already completed, else 0.
   - Stimulus: start+abort in the same cycle.
   - Required: stays IDLE.
5. Ignored starts and config latching:
   - Stimulus: start while busy; change cfg_half_period mid-sequence.
   - Required: timing and pitch unchanged.
   - Stimulus: start with enable=0.
   - Required: busy stays 0.
   - Stimulus: drop enable mid-GAP.
   - Required: IDLE next cycle.
6. Back-to-back:
   - Stimulus: gap=0, rep=3, dur=1, half=3.
   - Required: continuous 30-cycle burst; tone phase restarts high at cycles 10 and 20; beep_count steps 1,2,3; done=1.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer tone sequencer.
//   state_t  : sequencer FSM states (IDLE, PLAY, GAP)
//   DUR_W    : width of the duration / gap fields and their tick counter
//   REP_W    : width of the repeat field and the beep counter
//   tick_div : clock cycles per duration tick
package buzzer_pkg;

    localparam int DUR_W = 16;
    localparam int REP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Cycles per duration tick. The ratio must be exact and at least 2.
    function automatic int unsigned tick_div(input int unsigned clk_freq_hz,
                                             input int unsigned tick_hz);
        return clk_freq_hz / tick_hz;
    endfunction

endpackage

// File: rtl/buzzer_tone_seq_if.sv
// Register-file <-> tone-sequencer link.
//   ctrl_enable      : block enable level
//   ctrl_start       : one-cycle start pulse
//   ctrl_abort       : one-cycle abort pulse
//   cfg_half_period  : clocks per tone half-cycle (0 = rest)
//   cfg_duration     : on-time per beep in ticks
//   cfg_gap          : silence after each non-final beep in ticks
//   cfg_repeat       : beeps per sequence (0 behaves as 1)
//   busy / done / beep_count : status returned for readback
// master = register file side, slave = sequencer side.
interface buzzer_tone_seq_if
    import buzzer_pkg::*;
#(
    parameter int unsigned HP_WIDTH = 32
);
    logic                ctrl_enable;
    logic                ctrl_start;
    logic                ctrl_abort;
    logic [HP_WIDTH-1:0] cfg_half_period;
    logic [DUR_W-1:0]    cfg_duration;
    logic [DUR_W-1:0]    cfg_gap;
    logic [REP_W-1:0]    cfg_repeat;
    logic                busy;
    logic                done;
    logic [REP_W-1:0]    beep_count;

    modport master (
        output ctrl_enable, ctrl_start, ctrl_abort,
        output cfg_half_period, cfg_duration, cfg_gap, cfg_repeat,
        input  busy, done, beep_count
    );

    modport slave (
        input  ctrl_enable, ctrl_start, ctrl_abort,
        input  cfg_half_period, cfg_duration, cfg_gap, cfg_repeat,
        output busy, done, beep_count
    );
endinterface

// File: rtl/buzzer_tick_prescaler.sv
// Duration time-base prescaler.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   clear : restart the count from 0 on the next edge
//   run   : count enable
//   tick  : one-cycle pulse on the last cycle of every DIV-cycle window
//           while run is high
module buzzer_tick_prescaler #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // tick deliberately ignores clear: the FSM restarts the window on the
    // same edge that consumes the final tick of a segment.
    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/buzzer_tone_seq.sv
// Buzzer tone sequencer.
// Plays cfg_repeat beeps: each beep is a square wave of period
// 2*cfg_half_period clocks lasting cfg_duration ticks, separated by
// cfg_gap ticks of silence. Configuration is captured on an accepted start.
//   s00_axi_aclk    : clock
//   s00_axi_aresetn : asynchronous active-low reset
//   regs            : control/config inputs and status outputs (slave side)
//   buzzer_out      : registered tone output
module buzzer_tone_seq
    import buzzer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned TICK_HZ     = 1000,
    parameter int unsigned HP_WIDTH    = 32
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    buzzer_tone_seq_if.slave        regs,
    output logic                    buzzer_out
);
    localparam int unsigned TICK_DIV = tick_div(CLK_FREQ_HZ, TICK_HZ);

    state_t              state_q, state_d;
    logic                buzzer_q, buzzer_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [REP_W-1:0]    beep_count_q, beep_count_d;
    logic [HP_WIDTH-1:0] tone_cnt_q, tone_cnt_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [HP_WIDTH-1:0] hp_q, hp_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [DUR_W-1:0]    gap_q, gap_d;
    logic [REP_W-1:0]    rep_q, rep_d;

    logic                presc_clear;
    logic                presc_run;
    logic                tick;

    logic                start_ok;
    logic                stop_req;
    logic                hp_nonzero;
    logic                tone_last;
    logic [DUR_W-1:0]    seg_limit;
    logic [DUR_W:0]      seg_next;
    logic                seg_done;
    logic                last_beep;

    buzzer_tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (s00_axi_aclk),
        .rst_n (s00_axi_aresetn),
        .clear (presc_clear),
        .run   (presc_run),
        .tick  (tick)
    );

    assign presc_run  = (state_q != IDLE);
    // Abort is checked first so a simultaneous start is dropped.
    assign start_ok   = regs.ctrl_start && regs.ctrl_enable && !regs.ctrl_abort;
    assign stop_req   = regs.ctrl_abort || !regs.ctrl_enable;
    assign hp_nonzero = (hp_q != '0);
    assign tone_last  = (tone_cnt_q == hp_q - HP_WIDTH'(1));

    // One counter serves both PLAY (limit = duration) and GAP (limit = gap).
    // The segment ends on the edge of the tick that would make the count
    // equal the limit, so a segment of D ticks lasts exactly D*TICK_DIV
    // cycles; a zero limit ends the segment after a single cycle.
    assign seg_limit  = (state_q == GAP) ? gap_q : dur_q;
    assign seg_next   = (DUR_W+1)'(dur_cnt_q) + (DUR_W+1)'(1);
    assign seg_done   = (dur_cnt_q == seg_limit) ||
                        (tick && (seg_next == (DUR_W+1)'(seg_limit)));
    assign last_beep  = ((beep_count_q + REP_W'(1)) == rep_q);

    always_comb begin
        state_d      = state_q;
        buzzer_d     = buzzer_q;
        busy_d       = busy_q;
        done_d       = done_q;
        beep_count_d = beep_count_q;
        tone_cnt_d   = tone_cnt_q;
        dur_cnt_d    = dur_cnt_q;
        hp_d         = hp_q;
        dur_d        = dur_q;
        gap_d        = gap_q;
        rep_d        = rep_q;
        presc_clear  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    hp_d         = regs.cfg_half_period;
                    dur_d        = regs.cfg_duration;
                    gap_d        = regs.cfg_gap;
                    // Zero repeat behaves as a single beep.
                    rep_d        = (regs.cfg_repeat == '0) ? REP_W'(1) : regs.cfg_repeat;
                    state_d      = PLAY;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    beep_count_d = '0;
                    tone_cnt_d   = '0;
                    dur_cnt_d    = '0;
                    presc_clear  = 1'b1;
                    buzzer_d     = (regs.cfg_half_period != '0);
                end
            end

            PLAY: begin
                if (stop_req) begin
                    state_d     = IDLE;
                    buzzer_d    = 1'b0;
                    busy_d      = 1'b0;
                    tone_cnt_d  = '0;
                    dur_cnt_d   = '0;
                    presc_clear = 1'b1;
                end else if (seg_done) begin
                    beep_count_d = beep_count_q + REP_W'(1);
                    tone_cnt_d   = '0;
                    dur_cnt_d    = '0;
                    presc_clear  = 1'b1;
                    if (last_beep) begin
                        state_d  = IDLE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        buzzer_d = 1'b0;
                    end else if (gap_q == '0) begin
                        // Back-to-back beep: tone phase restarts high.
                        state_d  = PLAY;
                        buzzer_d = hp_nonzero;
                    end else begin
                        state_d  = GAP;
                        buzzer_d = 1'b0;
                    end
                end else begin
                    if (tick) begin
                        dur_cnt_d = dur_cnt_q + DUR_W'(1);
                    end
                    // A zero half-period is a rest: output held low.
                    if (hp_nonzero) begin
                        if (tone_last) begin
                            tone_cnt_d = '0;
                            buzzer_d   = ~buzzer_q;
                        end else begin
                            tone_cnt_d = tone_cnt_q + HP_WIDTH'(1);
                        end
                    end
                end
            end

            GAP: begin
                buzzer_d = 1'b0;
                if (stop_req) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    dur_cnt_d   = '0;
                    presc_clear = 1'b1;
                end else if (seg_done) begin
                    state_d     = PLAY;
                    tone_cnt_d  = '0;
                    dur_cnt_d   = '0;
                    presc_clear = 1'b1;
                    buzzer_d    = hp_nonzero;
                end else if (tick) begin
                    dur_cnt_d = dur_cnt_q + DUR_W'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                buzzer_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q      <= IDLE;
            buzzer_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            beep_count_q <= '0;
            tone_cnt_q   <= '0;
            dur_cnt_q    <= '0;
            hp_q         <= '0;
            dur_q        <= '0;
            gap_q        <= '0;
            rep_q        <= '0;
        end else begin
            state_q      <= state_d;
            buzzer_q     <= buzzer_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            beep_count_q <= beep_count_d;
            tone_cnt_q   <= tone_cnt_d;
            dur_cnt_q    <= dur_cnt_d;
            hp_q         <= hp_d;
            dur_q        <= dur_d;
            gap_q        <= gap_d;
            rep_q        <= rep_d;
        end
    end

    assign buzzer_out      = buzzer_q;
    assign regs.busy       = busy_q;
    assign regs.done       = done_q;
    assign regs.beep_count = beep_count_q;
endmodule

// File: tb/tb_buzzer_tone_seq.sv
// Self-checking bench for buzzer_tone_seq (1 kHz clock, 100 Hz tick).
module tb_buzzer_tone_seq;
    localparam int unsigned TICK = 10;

    logic clk;
    logic rst_n;
    logic buzzer_out;

    buzzer_tone_seq_if #(.HP_WIDTH(32)) bus ();

    buzzer_tone_seq #(
        .CLK_FREQ_HZ (1000),
        .TICK_HZ     (100),
        .HP_WIDTH    (32)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .regs            (bus),
        .buzzer_out      (buzzer_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int unsigned half;
        int unsigned dur;
        int unsigned gap;
        int unsigned rep;
        int unsigned exp_len;
        int unsigned exp_beeps;
    } vec_t;

    typedef struct {
        logic       buz;
        logic [7:0] cnt;
    } cyc_t;

    vec_t vecs[6];
    cyc_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle waveform and beep count, built from the sequence
    // description: PLAY of dur*TICK cycles (1 if dur==0), tone high for the
    // first half-period, then GAP of gap*TICK silent cycles between beeps.
    task automatic build_model(input vec_t v);
        int unsigned rep_eff;
        int unsigned play_len;
        cyc_t e;
        rep_eff  = (v.rep == 0) ? 1 : v.rep;
        play_len = (v.dur == 0) ? 1 : v.dur * TICK;
        for (int unsigned b = 0; b < rep_eff; b++) begin
            for (int unsigned i = 0; i < play_len; i++) begin
                e.buz = (v.half == 0) ? 1'b0 : (((i / v.half) % 2) == 0);
                e.cnt = 8'(b);
                sb_q.push_back(e);
            end
            if ((b != rep_eff - 1) && (v.gap != 0)) begin
                for (int unsigned i = 0; i < v.gap * TICK; i++) begin
                    e.buz = 1'b0;
                    e.cnt = 8'(b + 1);
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    task automatic set_cfg(input int unsigned half, input int unsigned dur,
                           input int unsigned gap, input int unsigned rep);
        bus.cfg_half_period = half;
        bus.cfg_duration    = 16'(dur);
        bus.cfg_gap         = 16'(gap);
        bus.cfg_repeat      = 8'(rep);
    endtask

    // Pulse start; returns at the negedge of the first cycle after acceptance.
    task automatic start_only(input int unsigned half, input int unsigned dur,
                              input int unsigned gap, input int unsigned rep);
        set_cfg(half, dur, gap, rep);
        @(negedge clk);
        bus.ctrl_start = 1'b1;
        @(negedge clk);
        bus.ctrl_start = 1'b0;
    endtask

    task automatic run_vec(input int idx, input bit disturb);
        vec_t v;
        cyc_t e;
        int unsigned busy_cycles;
        int unsigned cyc;
        v = vecs[idx];
        build_model(v);
        busy_cycles = 0;
        cyc = 0;
        start_only(v.half, v.dur, v.gap, v.rep);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cyc++;
            chk($sformatf("v%0d_buzzer_c%0d", idx, cyc), 32'(buzzer_out), 32'(e.buz));
            chk($sformatf("v%0d_count_c%0d", idx, cyc), 32'(bus.beep_count), 32'(e.cnt));
            if (bus.busy) busy_cycles++;
            if (disturb && cyc == 5) bus.ctrl_start = 1'b1;
            if (disturb && cyc == 6) begin
                bus.ctrl_start      = 1'b0;
                bus.cfg_half_period = 7;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d_busy_len", idx), busy_cycles, v.exp_len);
        chk($sformatf("v%0d_busy_end", idx), 32'(bus.busy), 32'd0);
        chk($sformatf("v%0d_done", idx), 32'(bus.done), 32'd1);
        chk($sformatf("v%0d_beeps", idx), 32'(bus.beep_count), v.exp_beeps);
        chk($sformatf("v%0d_buzzer_end", idx), 32'(buzzer_out), 32'd0);
        $display("vec %0d half=%0d dur=%0d gap=%0d rep=%0d busy_cycles=%0d beeps=%0d",
                 idx, v.half, v.dur, v.gap, v.rep, busy_cycles, bus.beep_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          half dur gap rep len beeps
        vecs[0] = '{2, 3, 2, 2, 80, 2};
        vecs[1] = '{0, 3, 0, 1, 30, 1};
        vecs[2] = '{1, 0, 5, 0,  1, 1};
        vecs[3] = '{3, 1, 0, 3, 30, 3};
        vecs[4] = '{1, 2, 1, 3, 80, 3};
        vecs[5] = '{5, 0, 1, 2, 12, 2};

        rst_n          = 1'b0;
        bus.ctrl_enable = 1'b1;
        bus.ctrl_start  = 1'b0;
        bus.ctrl_abort  = 1'b0;
        set_cfg(2, 3, 2, 2);

        // Reset held: inputs toggling must not disturb the outputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.ctrl_start = ~bus.ctrl_start;
        end
        @(negedge clk);
        bus.ctrl_start = 1'b0;
        chk("rst_buzzer", 32'(buzzer_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_beeps", 32'(bus.beep_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        $display("reset held with toggling inputs");

        for (int i = 0; i < 6; i++) begin
            run_vec(i, 1'b0);
        end

        // Start while busy and a mid-sequence pitch change are both ignored.
        run_vec(0, 1'b1);

        // Reset mid-PLAY: output drops without waiting for a clock edge.
        start_only(2, 3, 2, 2);
        chk("midrst_buzzer_before", 32'(buzzer_out), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_buzzer", 32'(buzzer_out), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset asserted mid-PLAY");

        // Abort 12 cycles into the first PLAY: no beep completed yet.
        start_only(2, 3, 2, 3);
        repeat (11) @(negedge clk);
        bus.ctrl_abort = 1'b1;
        @(negedge clk);
        bus.ctrl_abort = 1'b0;
        chk("abort0_busy", 32'(bus.busy), 32'd0);
        chk("abort0_buzzer", 32'(buzzer_out), 32'd0);
        chk("abort0_done", 32'(bus.done), 32'd0);
        chk("abort0_beeps", 32'(bus.beep_count), 32'd0);
        $display("abort during first beep");

        // Abort after the first beep has completed.
        start_only(2, 1, 1, 3);
        repeat (14) @(negedge clk);
        bus.ctrl_abort = 1'b1;
        @(negedge clk);
        bus.ctrl_abort = 1'b0;
        chk("abort1_busy", 32'(bus.busy), 32'd0);
        chk("abort1_buzzer", 32'(buzzer_out), 32'd0);
        chk("abort1_done", 32'(bus.done), 32'd0);
        chk("abort1_beeps", 32'(bus.beep_count), 32'd1);
        $display("abort after first beep");

        // Start and abort together: abort wins.
        @(negedge clk);
        bus.ctrl_start = 1'b1;
        bus.ctrl_abort = 1'b1;
        @(negedge clk);
        bus.ctrl_start = 1'b0;
        bus.ctrl_abort = 1'b0;
        chk("startabort_busy", 32'(bus.busy), 32'd0);
        chk("startabort_buzzer", 32'(buzzer_out), 32'd0);
        @(negedge clk);
        chk("startabort_busy2", 32'(bus.busy), 32'd0);
        $display("start with abort dropped");

        // Start with enable low is ignored.
        bus.ctrl_enable = 1'b0;
        start_only(2, 3, 2, 2);
        chk("disabled_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("disabled_busy2", 32'(bus.busy), 32'd0);
        bus.ctrl_enable = 1'b1;
        $display("start with enable low ignored");

        // Enable dropped in the first GAP (cycles 31..50).
        start_only(2, 3, 2, 2);
        repeat (34) @(negedge clk);
        chk("engap_in_gap_busy", 32'(bus.busy), 32'd1);
        bus.ctrl_enable = 1'b0;
        @(negedge clk);
        chk("engap_busy", 32'(bus.busy), 32'd0);
        chk("engap_buzzer", 32'(buzzer_out), 32'd0);
        chk("engap_beeps", 32'(bus.beep_count), 32'd1);
        chk("engap_done", 32'(bus.done), 32'd0);
        bus.ctrl_enable = 1'b1;
        $display("enable dropped during gap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
